bcd_sevenseg_scanner: RTL and testbench

//  Time-multiplexed 2-digit seven-segment driver. Sits directly downstream of the
//  mod-60 BCD up/down counter and consumes its high/low digit outputs.
//  - Latches a tear-free snapshot of both digits once per frame.
//  - Scans the two digit anodes with a ghosting guard interval.
//  - Supports leading-zero blanking, blinking and invalid-BCD flagging.

---
 rtl/bcd_sevenseg_scanner_pkg.sv | 46 ++++
 rtl/bcd_sevenseg_scanner_bcd_to_7seg.sv | 29 ++
 rtl/bcd_sevenseg_scanner.sv | 141 ++++++++++++++
 tb/tb_bcd_sevenseg_scanner.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_sevenseg_scanner_pkg.sv
// Purpose: shared types and constants for the two-digit seven-segment scanner.
//   Scan state encoding, the snapshot payload, segment patterns and anode codes.
package bcd_sevenseg_scanner_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 2;

  typedef enum logic [1:0] {
    BLANK_L = 2'd0,
    SHOW_L  = 2'd1,
    BLANK_H = 2'd2,
    SHOW_H  = 2'd3
  } scan_state_t;

  // Per-frame snapshot of the counter digits
  typedef struct packed {
    logic [DIGIT_W-1:0] high;
    logic [DIGIT_W-1:0] low;
  } bcd_pair_t;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, logical active-high
  localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  // Anode codes: an[1] = tens, an[0] = units
  localparam logic [AN_W-1:0] AN_OFF  = 2'b00;
  localparam logic [AN_W-1:0] AN_LOW  = 2'b01;
  localparam logic [AN_W-1:0] AN_HIGH = 2'b10;

  // Either digit outside 0..9
  function automatic logic is_bcd_err(input bcd_pair_t p);
    return (p.high > DIGIT_W'(9)) || (p.low > DIGIT_W'(9));
  endfunction

endpackage

// File: rtl/bcd_sevenseg_scanner_bcd_to_7seg.sv
// Purpose: combinational BCD digit to seven-segment decoder; non-BCD codes show 'E'.
// Ports:
//   digit  in  4  BCD digit
//   seg_c  out 7  segment pattern {g,f,e,d,c,b,a}, logical active-high
module bcd_to_7seg
  import bcd_sevenseg_scanner_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_E;
    case (digit)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_sevenseg_scanner.sv
// Purpose: time-multiplexed two-digit seven-segment driver with per-frame digit
//   snapshot, anode guard interval, leading-zero blanking, blinking and BCD error flag.
// Ports:
//   clock      in   1  clock, all state on posedge
//   reset      in   1  synchronous active-high reset
//   high       in   4  tens digit from the counter
//   low        in   4  units digit from the counter
//   lz_blank   in   1  suppress tens digit when it is 0
//   blink_en   in   1  gate display with the blink phase
//   seg        out  7  segment pins {g,f,e,d,c,b,a}
//   an         out  2  anode pins, an[1]=tens, an[0]=units
//   frame_tick out  1  pulse on the first cycle of each frame
//   bcd_err    out  1  snapshot holds a digit above 9
module bcd_sevenseg_scanner
  import bcd_sevenseg_scanner_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV   = 50000,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DIGIT_W-1:0] high,
  input  logic [DIGIT_W-1:0] low,
  input  logic               lz_blank,
  input  logic               blink_en,
  output logic [SEG_W-1:0]   seg,
  output logic [AN_W-1:0]    an,
  output logic               frame_tick,
  output logic               bcd_err
);

  localparam int unsigned SLOT_W  = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(PRESCALE_DIV - 1);
  localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES / 2);

  scan_state_t        state, state_nxt;
  logic [SLOT_W-1:0]  slot_cnt, slot_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;
  bcd_pair_t          snap, snap_nxt;
  logic               tick_cur, tick_nxt;
  logic [DIGIT_W-1:0] digit_sel;
  logic [SEG_W-1:0]   seg_dec;
  logic [SEG_W-1:0]   seg_d, seg_q;
  logic [AN_W-1:0]    an_d, an_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= BLANK_L;
    else       state <= state_nxt;
  end

  // Next-state logic plus the counters and snapshot that advance with it
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot_cnt + SLOT_W'(1);
    if (slot_cnt == SLOT_LAST) slot_nxt = '0;
    case (state)
      BLANK_L: if (slot_cnt == BLANK_LAST) state_nxt = SHOW_L;
      SHOW_L:  if (slot_cnt == SLOT_LAST)  state_nxt = BLANK_H;
      BLANK_H: if (slot_cnt == BLANK_LAST) state_nxt = SHOW_H;
      SHOW_H:  if (slot_cnt == SLOT_LAST)  state_nxt = BLANK_L;
      default: state_nxt = BLANK_L;
    endcase

    tick_cur = (state == BLANK_L) && (slot_cnt == '0);
    tick_nxt = (state_nxt == BLANK_L) && (slot_nxt == '0);

    snap_nxt = snap;
    if (tick_cur) snap_nxt = '{high: high, low: low};

    // Advance the blink count on entry to a new frame, so it is constant across the frame
    blink_nxt = blink_cnt;
    if (tick_nxt) blink_nxt = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + BLINK_W'(1);
  end

  assign digit_sel = (state_nxt == SHOW_H) ? snap_nxt.high : snap_nxt.low;

  bcd_to_7seg u_dec (
    .digit (digit_sel),
    .seg_c (seg_dec)
  );

  // Output logic evaluated on next-cycle values so the registered pins line up with state
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    case (state_nxt)
      SHOW_L: begin
        seg_d = seg_dec;
        an_d  = AN_LOW;
      end
      SHOW_H: begin
        if (!(lz_blank && (snap_nxt.high == '0))) begin
          seg_d = seg_dec;
          an_d  = AN_HIGH;
        end
      end
      default: begin
        seg_d = SEG_OFF;
        an_d  = AN_OFF;
      end
    endcase
    if (blink_en && (blink_nxt >= BLINK_HALF)) begin
      seg_d = SEG_OFF;
      an_d  = AN_OFF;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt   <= '0;
      blink_cnt  <= '0;
      snap       <= '0;
      bcd_err    <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
      frame_tick <= 1'b1;
    end else begin
      slot_cnt   <= slot_nxt;
      blink_cnt  <= blink_nxt;
      snap       <= snap_nxt;
      if (tick_cur) bcd_err <= is_bcd_err(snap_nxt);
      seg_q      <= seg_d;
      an_q       <= an_d;
      frame_tick <= tick_nxt;
    end
  end

  // Pin polarity after the register
  assign seg = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
  assign an  = ACTIVE_LOW_AN  ? ~an_q  : an_q;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Purpose: self-checking bench for bcd_sevenseg_scanner. A frame-position model
//   produces per-cycle expectations into a scoreboard queue; a negedge monitor
//   pops and compares them against the DUT outputs.
module tb_bcd_sevenseg_scanner;

  localparam int P  = 8;
  localparam int BL = 2;
  localparam int BF = 4;
  localparam int FR = 2 * P;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       tick;
    logic       err;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] high, low;
  logic       lz_blank, blink_en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick, bcd_err;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int         m_pos   = 0;
  int         m_frame = 0;
  logic [3:0] m_hi    = 4'd0;
  logic [3:0] m_lo    = 4'd0;
  logic       m_err   = 1'b0;

  bcd_sevenseg_scanner #(
    .PRESCALE_DIV   (P),
    .BLANK_CYCLES   (BL),
    .BLINK_FRAMES   (BF),
    .ACTIVE_LOW_SEG (1'b0),
    .ACTIVE_LOW_AN  (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .high       (high),
    .low        (low),
    .lz_blank   (lz_blank),
    .blink_en   (blink_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick),
    .bcd_err    (bcd_err)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  // One clock: advance the model on the edge using the inputs held before it, queue expectations
  task automatic step();
    exp_t e;
    @(posedge clock);
    if (reset) begin
      m_pos = 0; m_frame = 0; m_hi = 4'd0; m_lo = 4'd0; m_err = 1'b0;
    end else begin
      if (m_pos == 0) begin
        m_hi  = high;
        m_lo  = low;
        m_err = (high > 4'd9) || (low > 4'd9);
      end
      m_pos = (m_pos + 1) % FR;
      if (m_pos == 0) m_frame++;
    end
    e.tick = (m_pos == 0);
    e.err  = m_err;
    e.seg  = 7'h00;
    e.an   = 2'b00;
    if (!reset) begin
      if (m_pos >= BL && m_pos < P) begin
        e.an  = 2'b01;
        e.seg = seg_of(m_lo);
      end else if (m_pos >= P + BL) begin
        if (!(lz_blank && m_hi == 4'd0)) begin
          e.an  = 2'b10;
          e.seg = seg_of(m_hi);
        end
      end
      if (blink_en && (m_frame % BF) >= BF / 2) begin
        e.an  = 2'b00;
        e.seg = 7'h00;
      end
    end
    sb_q.push_back(e);
    #1;
  endtask

  task automatic run_frames(input int n);
    repeat (n * FR) step();
  endtask

  task automatic wait_pos(input int p);
    int guard = 0;
    while (m_pos != p && guard < 2 * FR) begin
      step();
      guard++;
    end
  endtask

  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq("seg",        8'(seg),        8'(e.seg));
      check_eq("an",         8'(an),         8'(e.an));
      check_eq("frame_tick", 8'(frame_tick), 8'(e.tick));
      check_eq("bcd_err",    8'(bcd_err),    8'(e.err));
    end
  end

  initial begin
    reset    = 1'b1;
    high     = 4'd5;
    low      = 4'd9;
    lz_blank = 1'b0;
    blink_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Steady 59
    run_frames(2);

    // Mid-frame change of the units digit
    wait_pos(5);
    low = 4'd3;
    run_frames(2);

    // Leading-zero blanking on and off
    high = 4'd0; low = 4'd7; lz_blank = 1'b1;
    run_frames(2);
    lz_blank = 1'b0;
    run_frames(2);

    // Invalid BCD then recovery
    high = 4'hC; low = 4'd2;
    run_frames(2);
    high = 4'd1;
    run_frames(2);

    // Blinking across two blink periods
    blink_en = 1'b1;
    run_frames(8);

    // Reset in the tens display slot
    blink_en = 1'b0;
    high = 4'd8; low = 4'd4;
    wait_pos(P + BL + 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_frames(2);

    @(negedge clock);
    #1;
    check_eq("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
